// File: rtl/reg_readout_serializer.sv
// Snapshots a parallel register value on request and streams it out as beats
// over valid/ready, optionally followed by an XOR checksum beat.
module reg_readout_serializer #(
  parameter int DATA_W    = 64,
  parameter int BYTE_W    = 8,
  parameter int LSB_FIRST = 1,
  parameter int CKSUM     = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_req,
  input  logic [DATA_W-1:0] d_in,
  input  logic              tx_ready,
  output logic [BYTE_W-1:0] tx_data,
  output logic              tx_valid,
  output logic              tx_last,
  output logic              busy,
  output logic              done,
  output logic              req_drop
);

  localparam int NB     = DATA_W / BYTE_W;
  localparam int NBEATS = NB + ((CKSUM != 0) ? 1 : 0);
  localparam int IDX_W  = $clog2(NBEATS + 1);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBEATS - 1);
  localparam logic [IDX_W-1:0] NB_IDX   = IDX_W'(NB);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_SEND = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [DATA_W-1:0] shadow_q, shadow_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [BYTE_W-1:0] cksum_q, cksum_d;
  logic [BYTE_W-1:0] tx_data_q, tx_data_d;
  logic              tx_last_q, tx_last_d;
  logic              done_q, done_d;
  logic              req_drop_q, req_drop_d;
  logic              xfer;

  // Index values at or beyond NB select the running checksum.
  function automatic logic [BYTE_W-1:0] beat_at(input logic [DATA_W-1:0] sh,
                                                input logic [IDX_W-1:0]  idx,
                                                input logic [BYTE_W-1:0] ck);
    logic [BYTE_W-1:0] b;
    b = ck;
    for (int i = 0; i < NB; i++) begin
      if (idx == IDX_W'(i)) begin
        if (LSB_FIRST != 0) b = sh[i*BYTE_W +: BYTE_W];
        else                b = sh[(NB-1-i)*BYTE_W +: BYTE_W];
      end
    end
    return b;
  endfunction

  assign xfer = (state_q == S_SEND) && tx_ready;

  always_comb begin
    state_d    = state_q;
    shadow_d   = shadow_q;
    idx_d      = idx_q;
    cksum_d    = cksum_q;
    done_d     = 1'b0;
    req_drop_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (rd_req) begin
          shadow_d = d_in;
          idx_d    = '0;
          cksum_d  = '0;
          state_d  = S_SEND;
        end
      end
      S_SEND: begin
        if (rd_req) req_drop_d = 1'b1;
        if (xfer) begin
          idx_d = idx_q + IDX_W'(1);
          if (idx_q < NB_IDX) cksum_d = cksum_q ^ tx_data_q;
          if (idx_q == LAST_IDX) begin
            state_d = S_IDLE;
            idx_d   = '0;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are precomputed from next-state so they leave straight from flops.
    tx_data_d = '0;
    tx_last_d = 1'b0;
    if (state_d == S_SEND) begin
      tx_data_d = beat_at(shadow_d, idx_d, cksum_d);
      tx_last_d = (idx_d == LAST_IDX);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      shadow_q   <= '0;
      idx_q      <= '0;
      cksum_q    <= '0;
      tx_data_q  <= '0;
      tx_last_q  <= 1'b0;
      done_q     <= 1'b0;
      req_drop_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      shadow_q   <= shadow_d;
      idx_q      <= idx_d;
      cksum_q    <= cksum_d;
      tx_data_q  <= tx_data_d;
      tx_last_q  <= tx_last_d;
      done_q     <= done_d;
      req_drop_q <= req_drop_d;
    end
  end

  assign tx_data  = tx_data_q;
  assign tx_valid = (state_q == S_SEND);
  assign tx_last  = tx_last_q;
  assign busy     = (state_q == S_SEND);
  assign done     = done_q;
  assign req_drop = req_drop_q;

endmodule

// File: tb/tb_reg_readout_serializer.sv
// Bench for reg_readout_serializer: a default-config instance (LSB first, checksum)
// and an MSB-first/no-checksum instance, checked against a byte-queue model.
module tb_reg_readout_serializer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [63:0] d_in = '0;
  logic        tx_ready = 1'b0;
  logic        rd_req_a = 1'b0;
  logic        rd_req_b = 1'b0;
  logic        sel = 1'b0;

  logic [7:0] a_data, b_data, o_data;
  logic a_valid, a_last, a_busy, a_done, a_drop;
  logic b_valid, b_last, b_busy, b_done, b_drop;
  logic o_valid, o_last, o_busy, o_done, o_drop;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  reg_readout_serializer dut_a (
    .clk(clk), .rst(rst), .rd_req(rd_req_a), .d_in(d_in), .tx_ready(tx_ready),
    .tx_data(a_data), .tx_valid(a_valid), .tx_last(a_last), .busy(a_busy),
    .done(a_done), .req_drop(a_drop)
  );

  reg_readout_serializer #(.LSB_FIRST(0), .CKSUM(0)) dut_b (
    .clk(clk), .rst(rst), .rd_req(rd_req_b), .d_in(d_in), .tx_ready(tx_ready),
    .tx_data(b_data), .tx_valid(b_valid), .tx_last(b_last), .busy(b_busy),
    .done(b_done), .req_drop(b_drop)
  );

  assign o_data  = sel ? b_data  : a_data;
  assign o_valid = sel ? b_valid : a_valid;
  assign o_last  = sel ? b_last  : a_last;
  assign o_busy  = sel ? b_busy  : a_busy;
  assign o_done  = sel ? b_done  : a_done;
  assign o_drop  = sel ? b_drop  : a_drop;

  typedef struct {
    logic        msb;
    logic [63:0] d;
    logic [63:0] d_after;
    logic [15:0] pat;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_frame(input logic msb, input logic [63:0] d);
    logic [7:0] x;
    x = '0;
    for (int i = 0; i < 8; i++) begin
      if (msb) exp_q.push_back(d[(7-i)*8 +: 8]);
      else begin
        exp_q.push_back(d[i*8 +: 8]);
        x = x ^ d[i*8 +: 8];
      end
    end
    if (!msb) exp_q.push_back(x);
  endtask

  // Called at a negedge; returns at the negedge of the first frame cycle.
  task automatic start(input logic s, input logic [63:0] d, input logic [63:0] d_after);
    sel  = s;
    d_in = d;
    if (s) rd_req_b = 1'b1; else rd_req_a = 1'b1;
    push_frame(s, d);
    @(negedge clk);
    rd_req_a = 1'b0;
    rd_req_b = 1'b0;
    d_in     = d_after;
    chk("latency_valid", {63'd0, o_valid}, 64'd1);
    chk("latency_busy",  {63'd0, o_busy},  64'd1);
  endtask

  // Consumes the expected queue under a ready pattern; ends at cycle m+1.
  task automatic drain(input logic [15:0] pat);
    int c;
    logic [7:0] e;
    c = 0;
    while (exp_q.size() > 0 && c < 200) begin
      tx_ready = pat[c % 16];
      chk("valid", {63'd0, o_valid}, 64'd1);
      if (tx_ready) begin
        e = exp_q.pop_front();
        chk("beat_data", {56'd0, o_data}, {56'd0, e});
        chk("beat_last", {63'd0, o_last}, {63'd0, exp_q.size() == 0});
      end else begin
        chk("stall_data", {56'd0, o_data}, {56'd0, exp_q[0]});
        chk("stall_last", {63'd0, o_last}, {63'd0, exp_q.size() == 1});
      end
      @(negedge clk);
      c++;
    end
    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain_timeout: %0d beats left want 0", exp_q.size());
      exp_q.delete();
    end
    tx_ready = 1'b0;
    chk("done_pulse", {63'd0, o_done},  64'd1);
    chk("end_valid",  {63'd0, o_valid}, 64'd0);
    chk("end_busy",   {63'd0, o_busy},  64'd0);
    chk("end_last",   {63'd0, o_last},  64'd0);
  endtask

  initial begin
    vecs[0] = '{1'b0, 64'h0123_4567_89AB_CDEF, 64'h5555_AAAA_5555_AAAA, 16'hFFFF};
    vecs[1] = '{1'b1, 64'hFF00_0000_0000_0011, 64'h1234_5678_9ABC_DEF0, 16'hFFFF};
    vecs[2] = '{1'b0, 64'h0123_4567_89AB_CDEF, 64'hFFFF_FFFF_FFFF_FFFF, 16'h6969};
    vecs[3] = '{1'b0, 64'h0000_0000_0000_0001, 64'hFFFF_FFFF_FFFF_FFFF, 16'h6969};
    vecs[4] = '{1'b0, 64'hA5A5_0F0F_3C3C_1248, 64'h0,                   16'h3333};
    vecs[5] = '{1'b1, 64'hDEAD_BEEF_CAFE_F00D, 64'h0,                   16'h5555};

    #3;
    chk("rst_a_valid", {63'd0, a_valid}, 64'd0);
    chk("rst_a_data",  {56'd0, a_data},  64'd0);
    chk("rst_a_done",  {63'd0, a_done},  64'd0);
    chk("rst_b_valid", {63'd0, b_valid}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("idle_a_busy", {63'd0, a_busy},  64'd0);
    chk("idle_a_drop", {63'd0, a_drop},  64'd0);

    for (int v = 0; v < 6; v++) begin
      start(vecs[v].msb, vecs[v].d, vecs[v].d_after);
      drain(vecs[v].pat);
      @(negedge clk);
      chk("done_cleared", {63'd0, o_done}, 64'd0);
    end

    // Collision: request during SEND is dropped, frame continues intact.
    start(1'b0, 64'h1122_3344_5566_7788, 64'h0);
    tx_ready = 1'b0;
    rd_req_a = 1'b1;
    @(negedge clk);
    rd_req_a = 1'b0;
    chk("drop_pulse", {63'd0, a_drop}, 64'd1);
    @(negedge clk);
    chk("drop_clear", {63'd0, a_drop}, 64'd0);
    drain(16'hFFFF);
    @(negedge clk);

    // Held request: back-to-back frames with one idle cycle between.
    sel      = 1'b0;
    d_in     = 64'hCAFE_0000_BEEF_0001;
    rd_req_a = 1'b1;
    push_frame(1'b0, d_in);
    @(negedge clk);
    chk("held_valid", {63'd0, a_valid}, 64'd1);
    drain(16'hFFFF);
    d_in = 64'h0102_0304_0506_0708;
    push_frame(1'b0, d_in);
    @(negedge clk);
    rd_req_a = 1'b0;
    chk("held_restart_valid", {63'd0, a_valid}, 64'd1);
    chk("held_done_clear",    {63'd0, a_done},  64'd0);
    drain(16'hFFFF);
    @(negedge clk);

    // Reset mid-frame at beat 4, then a fresh frame.
    start(1'b0, 64'h0123_4567_89AB_CDEF, 64'h0);
    tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      logic [7:0] e;
      e = exp_q.pop_front();
      chk("pre_rst_data", {56'd0, a_data}, {56'd0, e});
      @(negedge clk);
    end
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_valid", {63'd0, a_valid}, 64'd0);
    chk("mid_rst_data",  {56'd0, a_data},  64'd0);
    chk("mid_rst_busy",  {63'd0, a_busy},  64'd0);
    chk("mid_rst_last",  {63'd0, a_last},  64'd0);
    exp_q.delete();
    tx_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_done",  {63'd0, a_done},  64'd0);
      chk("post_rst_valid", {63'd0, a_valid}, 64'd0);
    end
    start(1'b0, 64'h0000_0000_0000_0001, 64'hFFFF_FFFF_FFFF_FFFF);
    drain(16'h6969);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: sim time %0t want finish", $time);
    $fatal(1);
  end

endmodule
